// File: rtl/ofsram_burst_ctrl.sv
// ofsram_burst_ctrl: sequences single-word and burst read/write commands into
// off-chip SRAM strobes (OFRead/OFWrite), address (OFAdd) and write data.
// Optional feature macro: OFSRAM_BOUNDS_CHECK_EN -- when defined, a command
// whose last address would pass 0x1FFFF is accepted but completes with no
// strobes and raises cmd_err together with done.
//
// Handshakes (cmd, wr, rd): a transfer happens on a rising clk2 edge where
// valid && ready are both high. Ready/valid outputs depend only on state;
// valid inputs sampled outside their owning state are ignored.
module ofsram_burst_ctrl #(
  parameter int ACCESS_CYCLES = 2,
  parameter int LEN_W         = 8
) (
  input  logic             clk2,
  input  logic             NReset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [16:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [15:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             cmd_err,
  output logic [16:0]      OFAdd,
  output logic             OFRead,
  output logic             OFWrite,
  output logic [15:0]      OFDataout,
  input  logic [15:0]      OFDatain,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_WDATA = 3'd1,
    S_STROBE     = 3'd2,
    S_RD_HOLD    = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam logic [3:0] STROBE_LAST = 4'(ACCESS_CYCLES - 1);

  state_t           state_q, state_d;
  logic             wr_dir_q, wr_dir_d;
  logic [16:0]      add_q, add_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       scnt_q, scnt_d;
  logic [15:0]      dout_q, dout_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             ofread_q, ofread_d;
  logic             ofwrite_q, ofwrite_d;

`ifdef OFSRAM_BOUNDS_CHECK_EN
  logic        err_q, err_d;
  logic [17:0] end_addr;
  logic        out_of_range;

  // Last word address of the incoming command, one bit wider to see overflow
  assign end_addr     = {1'b0, cmd_addr} + 18'(cmd_len);
  assign out_of_range = end_addr > 18'h1FFFF;
`endif

  // Next-state and datapath updates; strobes follow the next state so they
  // are registered and aligned exactly with the STROBE state.
  always_comb begin
    state_d   = state_q;
    wr_dir_d  = wr_dir_q;
    add_d     = add_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    ofread_d  = 1'b0;
    ofwrite_d = 1'b0;
`ifdef OFSRAM_BOUNDS_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wr_dir_d = cmd_write;
          add_d    = cmd_addr;
          cnt_d    = cmd_len;
          scnt_d   = 4'd0;
          state_d  = cmd_write ? S_WAIT_WDATA : S_STROBE;
`ifdef OFSRAM_BOUNDS_CHECK_EN
          err_d = out_of_range;
          if (out_of_range) state_d = S_DONE;
`endif
        end
      end
      S_WAIT_WDATA: begin
        if (wr_valid) begin
          dout_d  = wr_data;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (scnt_q == STROBE_LAST) begin
          scnt_d = 4'd0;
          add_d  = add_q + 17'd1;
          if (!wr_dir_q) begin
            rdata_d = OFDatain;
            state_d = S_RD_HOLD;
          end else if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = S_WAIT_WDATA;
          end
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end
      S_RD_HOLD: begin
        if (rd_ready) begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = S_STROBE;
          end
        end
      end
      S_DONE: begin
        // Return the SRAM-side and read outputs to zero for IDLE
        add_d   = 17'd0;
        dout_d  = 16'd0;
        rdata_d = 16'd0;
        state_d = S_IDLE;
`ifdef OFSRAM_BOUNDS_CHECK_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    ofread_d  = (state_d == S_STROBE) && !wr_dir_d;
    ofwrite_d = (state_d == S_STROBE) && wr_dir_d;
  end

  // State and datapath registers; reset drops strobes and discards any burst
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state_q   <= S_IDLE;
      wr_dir_q  <= 1'b0;
      add_q     <= 17'd0;
      cnt_q     <= '0;
      scnt_q    <= 4'd0;
      dout_q    <= 16'd0;
      rdata_q   <= 16'd0;
      ofread_q  <= 1'b0;
      ofwrite_q <= 1'b0;
`ifdef OFSRAM_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_dir_q  <= wr_dir_d;
      add_q     <= add_d;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
      ofread_q  <= ofread_d;
      ofwrite_q <= ofwrite_d;
`ifdef OFSRAM_BOUNDS_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WAIT_WDATA);
  assign rd_valid  = (state_q == S_RD_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_data   = rdata_q;
  assign OFAdd     = add_q;
  assign OFRead    = ofread_q;
  assign OFWrite   = ofwrite_q;
  assign OFDataout = dout_q;
  assign dbg_state = state_q;
`ifdef OFSRAM_BOUNDS_CHECK_EN
  assign cmd_err   = done && err_q;
`else
  assign cmd_err   = 1'b0;
`endif

endmodule

// File: doc/ofsram_burst_ctrl.md
# ofsram_burst_ctrl

Burst controller that sits directly upstream of the off-chip SRAM wrapper. It turns single-word or burst read/write commands from the datapath into properly sequenced SRAM strobes, addresses and data. Write data arrives and read data leaves over valid/ready handshakes. It owns the SRAM-side signals OFAdd, OFRead, OFWrite and OFDataout, and consumes OFDatain.

## Interface
Parameters:
- ACCESS_CYCLES, 2: cycles each strobe is held per word. Legal range 1–15.
- LEN_W, 8: width of the burst length field.

Ports:
- clk2  in  1  system clock; all state changes on its rising edge.
- NReset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  17  start word address.
- cmd_len  in  LEN_W  burst length minus one (0 = one word).
- wr_data  in  16  write word.
- wr_valid  in  1  write word present.
- wr_ready  out  1  write word accepted when wr_valid && wr_ready.
- rd_data  out  16  read word, registered.
- rd_valid  out  1  read word present.
- rd_ready  in  1  consumer takes the word when rd_valid && rd_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a burst finishes.
- cmd_err  out  1  one-cycle pulse with done when a command is rejected (see Configuration).
- OFAdd  out  17  SRAM word address, registered.
- OFRead  out  1  SRAM read strobe, registered.
- OFWrite  out  1  SRAM write strobe, registered.
- OFDataout  out  16  SRAM write data, registered.
- OFDatain  in  16  SRAM read data.

## Operation
State machine has five states: IDLE, WAIT_WDATA, STROBE, RD_HOLD, DONE.

- **IDLE**
  - cmd_ready = 1; every other output is 0.
  - On handshake, latch the direction, load OFAdd ← cmd_addr, and load the remaining count ← cmd_len.
  - Go to WAIT_WDATA for a write or STROBE for a read.
- **WAIT_WDATA**
  - wr_ready = 1; strobes are low.
  - On handshake, OFDataout ← wr_data, then go to STROBE.
  - No timeout; the block waits indefinitely.
- **STROBE**
  - OFWrite (write) or OFRead (read) = 1 for exactly ACCESS_CYCLES consecutive cycles.
  - OFAdd and OFDataout are stable throughout.
  - A 4-bit strobe counter tracks the cycles.
  - On the last cycle of a read, rd_data ← OFDatain.
  - On the last cycle, OFAdd ← OFAdd + 1, taking effect the next cycle while the strobes are low.
- **Exit from STROBE**
  - Read: go to RD_HOLD.
  - Write with count = 0: go to DONE.
  - Write with count > 0: decrement count, go to WAIT_WDATA.
- **RD_HOLD**
  - rd_valid = 1; strobes are low; rd_data is held stable.
  - On handshake with count = 0: go to DONE.
  - On handshake with count > 0: decrement count, go to STROBE.
- **DONE**
  - done = 1 for one cycle, then go to IDLE.
  - busy is still 1 in DONE.
- **Invariants**
  - OFRead and OFWrite are never both 1.
  - Strobes are low for at least one cycle between consecutive words, so OFAdd never changes while a strobe is high.
- **Address arithmetic**
  - 17-bit modulo: 0x1FFFF + 1 wraps to 0x00000 (when the bounds check is compiled out).
- **Count arithmetic**
  - LEN_W-bit; words transferred = cmd_len + 1, up to 2^LEN_W.
- **Input sampling**
  - cmd_valid in any state other than IDLE is ignored (cmd_ready = 0).
  - wr_valid outside WAIT_WDATA is ignored.

## Timing
- **Reset values:** all outputs are 0 except cmd_ready = 1; the state is IDLE.
  - Reset asserted mid-burst drops the strobes asynchronously, discards the burst, and emits no done.
- **Command to first strobe:**
  - Read: strobe is high the cycle after acceptance.
  - Write: the cycle after the wr handshake.
- **Per-word cycles, with rd_ready / wr_valid held high:**
  - Read: ACCESS_CYCLES + 1 (3 by default).
  - Write: 1 + ACCESS_CYCLES (3 by default).
- **Read data:** rd_valid rises the cycle after the last OFRead cycle.
- **done timing:**
  - done occurs the cycle after the final strobe (write) or the final rd handshake (read).
  - cmd_ready returns the following cycle.
- **Backpressure:** rd_ready or wr_valid held low stretches RD_HOLD or WAIT_WDATA. The strobes stay low while stretched.

## Configuration
- Macro: OFSRAM_BOUNDS_CHECK_EN.
- **Defined:**
  - A command with cmd_addr + cmd_len > 0x1FFFF, computed at 18 bits, is still accepted.
  - The block goes straight to DONE with no strobes, and cmd_err pulses together with done.
- **Undefined:**
  - cmd_err is tied to 0 and the address wraps modulo 2^17.

## Test plan
- **Reset:** NReset = 0 mid-STROBE → OFRead/OFWrite go to 0 immediately, cmd_ready = 1 after release, no done.
- **Single write:** addr 0x00010, len 0, data 0xBEEF → OFWrite high 2 cycles with OFAdd = 0x00010 and OFDataout = 0xBEEF; done pulses the next cycle.
- **Read burst:** addr 0x00100, len 3, SRAM preloaded with 0x1111–0x4444, rd_ready = 1 → rd_data sequence 0x1111, 0x2222, 0x3333, 0x4444 at 3-cycle spacing; OFAdd runs 0x100–0x103.
- **Backpressure:** rd_ready low for 5 cycles mid-burst → rd_data is held, strobes stay low, no word is lost or duplicated.
- **Wrap boundary:** addr 0x1FFFE, len 2, write.
  - Without the macro: writes land at 0x1FFFE, 0x1FFFF, 0x00000.
  - With the macro: no strobes, and done and cmd_err pulse together.
- **Command while busy:** cmd_valid held during a burst → ignored until IDLE, then accepted exactly once.
